// File: rtl/gnn_seq_ctrl.sv
// ============================================================================
// gnn_seq_ctrl : sequencer for the 4-node GNN pipeline (load, stage go pulses,
//                per-stage timeout, completion). Option macro: GNN_PERF_CNT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module gnn_seq_ctrl #(
  parameter int TIMEOUT_CYC = 200,
  parameter int TMO_W       = 8,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              err_clr,
  input  logic              aggr1_rdy,
  input  logic              l1_rdy,
  input  logic              aggr2_rdy,
  input  logic              relu_rdy,
  input  logic              l2_rdy,
  output logic              load_en,
  output logic              aggr1_go,
  output logic              l1_go,
  output logic              aggr2_go,
  output logic              relu_go,
  output logic              l2_go,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_stage,
  output logic [PERF_W-1:0] cycle_cnt
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_AGGR1 = 4'd2,
    S_L1    = 4'd3,
    S_AGGR2 = 4'd4,
    S_RELU  = 4'd5,
    S_L2    = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  localparam logic [TMO_W-1:0] c_tmo = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] c_one = TMO_W'(1);
  localparam logic [TMO_W-1:0] c_two = TMO_W'(2);

  state_t           r_state;
  state_t           w_next;
  state_t           w_succ;
  logic [TMO_W-1:0] r_cnt;
  logic [2:0]       r_err_stage;
  logic [2:0]       w_stage_id;
  logic             w_rdy;
  logic             w_timeout;
  logic             w_in_stage;
  logic             w_first;

  // Per-stage view: which rdy to watch, the stage's error code and successor.
  always_comb begin
    w_rdy      = 1'b0;
    w_stage_id = 3'd0;
    w_succ     = S_IDLE;
    case (r_state)
      S_AGGR1: begin w_rdy = aggr1_rdy; w_stage_id = 3'd1; w_succ = S_L1;    end
      S_L1:    begin w_rdy = l1_rdy;    w_stage_id = 3'd2; w_succ = S_AGGR2; end
      S_AGGR2: begin w_rdy = aggr2_rdy; w_stage_id = 3'd3; w_succ = S_RELU;  end
      S_RELU:  begin w_rdy = relu_rdy;  w_stage_id = 3'd4; w_succ = S_L2;    end
      S_L2:    begin w_rdy = l2_rdy;    w_stage_id = 3'd5; w_succ = S_DONE;  end
      default: ;
    endcase
  end

  assign w_in_stage = (w_stage_id != 3'd0);

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_next = S_LOAD;
        S_LOAD: w_next = S_AGGR1;
        S_DONE: w_next = S_IDLE;
        S_ERR:  if (err_clr) w_next = S_IDLE;
        default: begin
          // rdy on the go cycle is a stale level from the previous run
          if (w_in_stage && (r_cnt >= c_two)) begin
            if (w_rdy) begin
              w_next = w_succ;
            end else if (r_cnt == c_tmo) begin
              w_next    = S_ERR;
              w_timeout = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) && (w_next >= S_AGGR1) && (w_next <= S_L2)) begin
      r_cnt <= c_one;
    end else if (w_in_stage) begin
      r_cnt <= r_cnt + c_one;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_stage <= 3'd0;
    end else if (abort) begin
      r_err_stage <= 3'd0;
    end else if (w_timeout) begin
      r_err_stage <= w_stage_id;
    end else if ((r_state == S_ERR) && err_clr) begin
      r_err_stage <= 3'd0;
    end
  end

  assign w_first   = (r_cnt == c_one);
  assign load_en   = (r_state == S_LOAD);
  assign aggr1_go  = (r_state == S_AGGR1) && w_first;
  assign l1_go     = (r_state == S_L1)    && w_first;
  assign aggr2_go  = (r_state == S_AGGR2) && w_first;
  assign relu_go   = (r_state == S_RELU)  && w_first;
  assign l2_go     = (r_state == S_L2)    && w_first;
  assign busy      = (r_state >= S_LOAD) && (r_state <= S_L2);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_ERR);
  assign err_stage = r_err_stage;

`ifdef GNN_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf;
  logic [PERF_W-1:0] r_cycle_cnt;
  logic [PERF_W-1:0] w_perf_inc;

  assign w_perf_inc = (&r_perf) ? r_perf : (r_perf + PERF_W'(1));

  // The LOAD cycle counts as 1; the DONE cycle is folded in on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf      <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && (w_next == S_LOAD)) begin
        r_perf <= PERF_W'(1);
      end else if (busy) begin
        r_perf <= w_perf_inc;
      end
      if ((r_state == S_L2) && (w_next == S_DONE)) begin
        r_cycle_cnt <= w_perf_inc;
      end
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`else
  assign cycle_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gnn_seq_ctrl.sv
// ============================================================================
// tb_gnn_seq_ctrl : scoreboard bench for gnn_seq_ctrl pulse order and timing
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gnn_seq_ctrl;

`ifdef GNN_PERF_CNT_EN
  localparam bit c_perf = 1'b1;
`else
  localparam bit c_perf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort, err_clr;
  logic        aggr1_rdy, l1_rdy, aggr2_rdy, relu_rdy, l2_rdy;
  logic        load_en, aggr1_go, l1_go, aggr2_go, relu_go, l2_go;
  logic        busy, done, err;
  logic [2:0]  err_stage;
  logic [15:0] cycle_cnt;

  gnn_seq_ctrl #(.TIMEOUT_CYC(200), .TMO_W(8), .PERF_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .err_clr(err_clr),
    .aggr1_rdy(aggr1_rdy), .l1_rdy(l1_rdy), .aggr2_rdy(aggr2_rdy),
    .relu_rdy(relu_rdy), .l2_rdy(l2_rdy),
    .load_en(load_en), .aggr1_go(aggr1_go), .l1_go(l1_go), .aggr2_go(aggr2_go),
    .relu_go(relu_go), .l2_go(l2_go), .busy(busy), .done(done), .err(err),
    .err_stage(err_stage), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tot = 0;
  int n_bad = 0;
  int last_cc = 0;

  typedef struct {int c; int k;} ev_t;
  ev_t q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input int k);
    ev_t e;
    e.c = c;
    e.k = k;
    q.push_back(e);
  endtask

  // Kinds: 0 load, 1 aggr1, 2 l1, 3 aggr2, 4 relu, 5 l2, 6 done
  task automatic push_run(input int t);
    push_ev(t + 1, 0); push_ev(t + 2, 1); push_ev(t + 4, 2); push_ev(t + 6, 3);
    push_ev(t + 8, 4); push_ev(t + 10, 5); push_ev(t + 12, 6);
  endtask

  always @(negedge clk) begin
    logic [6:0] p;
    p = {done, l2_go, relu_go, aggr2_go, l1_go, aggr1_go, load_en};
    for (int k = 0; k < 7; k++) begin
      if (p[k]) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", k, -1);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("pulse_kind", k, e.k);
          chk("pulse_cycle", cyc, e.c);
        end
      end
    end
  end

  task automatic run_clean();
    int t;
    t = cyc;
    start = 1'b1;
    push_run(t);
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      chk("clean_busy", int'(busy), int'(i <= 11));
      if (i == 12) begin
        chk("clean_done", int'(done), 1);
        chk("clean_cycle_cnt", int'(cycle_cnt), c_perf ? 12 : 0);
      end
      tick();
    end
    last_cc = c_perf ? 12 : 0;
    chk("clean_idle_busy", int'(busy), 0);
    chk("clean_queue", q.size(), 0);
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; abort = 1'b0; err_clr = 1'b0;
    aggr1_rdy = 1'b1; l1_rdy = 1'b1; aggr2_rdy = 1'b1; relu_rdy = 1'b1; l2_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_stage", int'(err_stage), 0);
    chk("rst_cycle_cnt", int'(cycle_cnt), 0);
    chk("rst_load_en", int'(load_en), 0);

    // 1) all rdy already high
    run_clean();

    // 2) l1 timeout, start ignored in ERR, err_clr back to IDLE
    l1_rdy = 1'b0;
    t = cyc;
    start = 1'b1;
    push_ev(t + 1, 0); push_ev(t + 2, 1); push_ev(t + 4, 2);
    tick();
    start = 1'b0;
    repeat (202) tick();
    chk("tmo_pre_err", int'(err), 0);
    chk("tmo_pre_busy", int'(busy), 1);
    tick();
    chk("tmo_err", int'(err), 1);
    chk("tmo_err_stage", int'(err_stage), 2);
    chk("tmo_busy", int'(busy), 0);
    start = 1'b1;
    tick();
    chk("tmo_start_ignored", int'(err), 1);
    start = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    l1_rdy = 1'b1;
    chk("clr_err", int'(err), 0);
    chk("clr_err_stage", int'(err_stage), 0);
    chk("tmo_cycle_cnt_held", int'(cycle_cnt), last_cc);
    chk("tmo_queue", q.size(), 0);

    // 3) relu_rdy rises exactly at counter==200
    relu_rdy = 1'b0;
    t = cyc;
    start = 1'b1;
    push_ev(t + 1, 0); push_ev(t + 2, 1); push_ev(t + 4, 2); push_ev(t + 6, 3);
    push_ev(t + 8, 4); push_ev(t + 208, 5); push_ev(t + 210, 6);
    tick();
    start = 1'b0;
    repeat (206) tick();
    chk("edge_pre_err", int'(err), 0);
    relu_rdy = 1'b1;
    tick();
    chk("edge_no_err", int'(err), 0);
    chk("edge_busy", int'(busy), 1);
    repeat (2) tick();
    chk("edge_cycle_cnt", int'(cycle_cnt), c_perf ? 210 : 0);
    last_cc = c_perf ? 210 : 0;
    tick();
    chk("edge_queue", q.size(), 0);

    // 4) abort in AGGR2 with aggr2_rdy high
    t = cyc;
    start = 1'b1;
    push_ev(t + 1, 0); push_ev(t + 2, 1); push_ev(t + 4, 2); push_ev(t + 6, 3);
    tick();
    start = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (20) tick();
    chk("abort_queue", q.size(), 0);
    chk("abort_cycle_cnt_held", int'(cycle_cnt), last_cc);
    run_clean();

    // aggr1 timeout, abort clears err_stage
    aggr1_rdy = 1'b0;
    t = cyc;
    start = 1'b1;
    push_ev(t + 1, 0); push_ev(t + 2, 1);
    tick();
    start = 1'b0;
    repeat (201) tick();
    chk("tmo1_err", int'(err), 1);
    chk("tmo1_err_stage", int'(err_stage), 1);
    aggr1_rdy = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("tmo1_abort_err", int'(err), 0);
    chk("tmo1_abort_stage", int'(err_stage), 0);

    // 5) start held high: back-to-back inferences
    t = cyc;
    start = 1'b1;
    push_run(t); push_run(t + 13); push_run(t + 26);
    for (int i = 0; i < 45; i++) begin
      tick();
      if (cyc == t + 13) chk("b2b_gap_busy", int'(busy), 0);
      if (cyc == t + 14) chk("b2b_reload_busy", int'(busy), 1);
      if (cyc == t + 30) start = 1'b0;
    end
    chk("b2b_idle", int'(busy), 0);
    chk("b2b_queue", q.size(), 0);

    // 6) rst mid-L2
    l2_rdy = 1'b0;
    t = cyc;
    start = 1'b1;
    push_ev(t + 1, 0); push_ev(t + 2, 1); push_ev(t + 4, 2); push_ev(t + 6, 3);
    push_ev(t + 8, 4); push_ev(t + 10, 5);
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_err", int'(err), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_err_stage", int'(err_stage), 0);
    chk("mrst_cycle_cnt", int'(cycle_cnt), 0);
    l2_rdy = 1'b1;
    repeat (10) tick();
    chk("mrst_stays_idle", int'(busy), 0);
    chk("mrst_queue", q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
